cmd_decoder_multi: RTL and testbench

CMD_DECODER_MULTI -- requirements
Module: cmd_decoder_multi

---
 rtl/cmd_decoder_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_cmd_decoder_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_decoder_multi.sv
// Byte-oriented command decoder for NCH DDS channels: LOAD/ENABLE/DISABLE/SET/READ/SET_ALL
// with ACK/NAK responses over a busy-gated UART transmit handshake.
module cmd_decoder_multi #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 received,
  input  logic [7:0]           rx_byte,
  input  logic                 tx_busy,
  output logic                 transmit,
  output logic [7:0]           tx_byte,
  output logic [NCH-1:0]       en,
  output logic [NCH*WIDTH-1:0] m,
  output logic [NCH-1:0]       set
);

  localparam int unsigned NB  = WIDTH / 8;
  localparam int unsigned BCW = $clog2(NB + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] ACK = 8'h41;
  localparam logic [7:0] NAK = 8'h4E;

  localparam logic [3:0] OP_LOAD    = 4'h1;
  localparam logic [3:0] OP_ENABLE  = 4'h2;
  localparam logic [3:0] OP_DISABLE = 4'h3;
  localparam logic [3:0] OP_SET     = 4'h4;
  localparam logic [3:0] OP_READ    = 4'h5;
  localparam logic [3:0] OP_SET_ALL = 4'h6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    EXEC    = 3'd2,
    READ_TX = 3'd3,
    RESP    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [3:0]         ch_q, ch_d;
  logic [WIDTH-1:0]   stage_q, stage_d;
  logic [BCW-1:0]     bcnt_q, bcnt_d;
  logic [TCW-1:0]     tmo_q, tmo_d;
  logic [BCW-1:0]     rd_q, rd_d;
  logic [7:0]         resp_q, resp_d;
  logic               done_q, done_d;

  logic               transmit_d;
  logic [7:0]         tx_byte_d;
  logic [NCH-1:0]     en_d;
  logic [NCH*WIDTH-1:0] m_d;
  logic [NCH-1:0]     set_d;

  logic [3:0]         cmd_op_c;
  logic [3:0]         cmd_ch_c;
  logic               op_ok_c;
  logic               ch_ok_c;
  logic [WIDTH-1:0]   word_c;
  logic [WIDTH-1:0]   rd_word_c;
  logic [7:0]         rd_byte_c;

  assign cmd_op_c = rx_byte[7:4];
  assign cmd_ch_c = rx_byte[3:0];
  assign op_ok_c  = (cmd_op_c >= OP_LOAD) && (cmd_op_c <= OP_SET_ALL);
  assign ch_ok_c  = (32'(cmd_ch_c) < NCH);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ch_d       = ch_q;
    stage_d    = stage_q;
    bcnt_d     = bcnt_q;
    tmo_d      = tmo_q;
    rd_d       = rd_q;
    resp_d     = resp_q;
    done_d     = done_q;
    en_d       = en;
    m_d        = m;
    set_d      = '0;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte;

    // Staging word with the incoming byte merged in at the current byte position
    word_c = stage_q;
    for (int b = 0; b < NB; b++) begin
      if (bcnt_q == BCW'(b)) word_c[b*8 +: 8] = rx_byte;
    end

    rd_word_c = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == 4'(c)) rd_word_c = m[c*WIDTH +: WIDTH];
    end
    rd_byte_c = '0;
    for (int b = 0; b < NB; b++) begin
      if (rd_q == BCW'(b)) rd_byte_c = rd_word_c[b*8 +: 8];
    end

    unique case (state_q)
      IDLE: begin
        if (received) begin
          op_d   = cmd_op_c;
          ch_d   = cmd_ch_c;
          done_d = 1'b0;
          rd_d   = '0;
          if (op_ok_c && (ch_ok_c || (cmd_op_c == OP_SET_ALL))) begin
            if (cmd_op_c == OP_LOAD) begin
              state_d = PAYLOAD;
              stage_d = '0;
              bcnt_d  = '0;
              tmo_d   = '0;
            end else begin
              state_d = EXEC;
              if (cmd_op_c == OP_SET_ALL) begin
                set_d = '1;
              end else if (cmd_op_c == OP_SET) begin
                for (int c = 0; c < NCH; c++) set_d[c] = (cmd_ch_c == 4'(c));
              end
            end
          end else begin
            resp_d  = NAK;
            state_d = RESP;
          end
        end
      end

      PAYLOAD: begin
        if (received) begin
          tmo_d   = '0;
          stage_d = word_c;
          bcnt_d  = bcnt_q + BCW'(1);
          if (bcnt_q == BCW'(NB - 1)) begin
            for (int c = 0; c < NCH; c++) begin
              if (ch_q == 4'(c)) m_d[c*WIDTH +: WIDTH] = word_c;
            end
            stage_d = '0;
            bcnt_d  = '0;
            resp_d  = ACK;
            state_d = RESP;
          end
        end else if (tmo_q == TCW'(TIMEOUT - 1)) begin
          stage_d = '0;
          bcnt_d  = '0;
          tmo_d   = '0;
          resp_d  = NAK;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end

      EXEC: begin
        resp_d  = ACK;
        state_d = RESP;
        unique case (op_q)
          OP_ENABLE: begin
            for (int c = 0; c < NCH; c++) if (ch_q == 4'(c)) en_d[c] = 1'b1;
          end
          OP_DISABLE: begin
            for (int c = 0; c < NCH; c++) if (ch_q == 4'(c)) en_d[c] = 1'b0;
          end
          OP_READ: begin
            rd_d    = '0;
            state_d = READ_TX;
          end
          default: ;
        endcase
      end

      READ_TX: begin
        if (!tx_busy) begin
          transmit_d = 1'b1;
          tx_byte_d  = rd_byte_c;
          rd_d       = rd_q + BCW'(1);
          state_d    = WAIT_TX;
        end
      end

      RESP: begin
        if (!tx_busy) begin
          transmit_d = 1'b1;
          tx_byte_d  = resp_q;
          done_d     = 1'b1;
          state_d    = WAIT_TX;
        end
      end

      WAIT_TX: begin
        // The transmit cycle itself never counts; the UART's busy shows up one cycle later
        if (!transmit && !tx_busy) begin
          if (done_q)                   state_d = IDLE;
          else if (rd_q == BCW'(NB))    state_d = RESP;
          else                          state_d = READ_TX;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      ch_q     <= '0;
      stage_q  <= '0;
      bcnt_q   <= '0;
      tmo_q    <= '0;
      rd_q     <= '0;
      resp_q   <= '0;
      done_q   <= 1'b0;
      transmit <= 1'b0;
      tx_byte  <= '0;
      en       <= '0;
      m        <= '0;
      set      <= '0;
    end else begin
      op_q     <= op_d;
      ch_q     <= ch_d;
      stage_q  <= stage_d;
      bcnt_q   <= bcnt_d;
      tmo_q    <= tmo_d;
      rd_q     <= rd_d;
      resp_q   <= resp_d;
      done_q   <= done_d;
      transmit <= transmit_d;
      tx_byte  <= tx_byte_d;
      en       <= en_d;
      m        <= m_d;
      set      <= set_d;
    end
  end

endmodule

// File: tb/tb_cmd_decoder_multi.sv
// Bench for cmd_decoder_multi: directed vector table, timeout/reset sequences and
// randomized command frames checked against a channel-level reference model.
module tb_cmd_decoder_multi;

  localparam int unsigned NCH     = 2;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 100;

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 received = 1'b0;
  logic [7:0]           rx_byte  = 8'h00;
  logic                 tx_busy  = 1'b0;
  logic                 transmit;
  logic [7:0]           tx_byte;
  logic [NCH-1:0]       en;
  logic [NCH*WIDTH-1:0] m;
  logic [NCH-1:0]       set;

  cmd_decoder_multi #(.NCH(NCH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .received (received),
    .rx_byte  (rx_byte),
    .tx_busy  (tx_busy),
    .transmit (transmit),
    .tx_byte  (tx_byte),
    .en       (en),
    .m        (m),
    .set      (set)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] rx;
    int          nrx;
    logic [47:0] tx;
    int          ntx;
    logic [1:0]  setv;
    logic [1:0]  en;
    logic [63:0] m;
    int          bp;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_strobe = 0;
  int bp_cycles = 0;
  int busy_left = 0;
  int busy_viol = 0;
  int stable_viol = 0;
  logic [7:0] prev_tx = 8'h00;
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  logic [1:0] set_q[$];

  logic [1:0]  en_m;
  logic [63:0] m_m;
  vec_t        tbl[14];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor plus a UART model that holds busy for bp_cycles after each transmit
  always @(negedge clk) begin
    if (transmit) begin
      if (tx_busy) busy_viol++;
      tx_q.push_back(tx_byte);
      tx_cyc_q.push_back(cyc);
      prev_tx = tx_byte;
    end else if (!rst_n) begin
      prev_tx = tx_byte;
    end else if (tx_byte !== prev_tx) begin
      stable_viol++;
    end
    if (set != 2'b00) set_q.push_back(set);
    if (transmit) busy_left = bp_cycles;
    else if (busy_left > 0) busy_left--;
    tx_busy = (busy_left > 0);
  end

  function automatic logic [47:0] b6(input logic [7:0] a0, input logic [7:0] a1 = 8'h00,
                                     input logic [7:0] a2 = 8'h00, input logic [7:0] a3 = 8'h00,
                                     input logic [7:0] a4 = 8'h00, input logic [7:0] a5 = 8'h00);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    received    = 1'b1;
    rx_byte     = b;
    last_strobe = cyc;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic start_frame(input int bp);
    bp_cycles = bp;
    tx_q.delete();
    tx_cyc_q.delete();
    set_q.delete();
  endtask

  task automatic finish_frame(input logic [47:0] etx, input int ntx, input logic [1:0] setv,
                              input bit lat_en, input string tag);
    int lat;
    for (int k = 0; k < 600 && tx_q.size() < ntx; k++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk({tag, "_txcount"}, 64'(tx_q.size()), 64'(ntx));
    for (int j = 0; j < ntx && j < tx_q.size(); j++)
      chk($sformatf("%s_tx%0d", tag, j), 64'(tx_q[j]), 64'(etx[j*8 +: 8]));
    chk({tag, "_setcount"}, 64'(set_q.size()), 64'(setv != 2'b00));
    if (setv != 2'b00 && set_q.size() > 0) chk({tag, "_setval"}, 64'(set_q[0]), 64'(setv));
    if (lat_en && bp_cycles == 0 && ntx == 1 && tx_cyc_q.size() > 0) begin
      lat = tx_cyc_q[0] - last_strobe;
      total++;
      if (lat > 3) begin
        bad++;
        $display("FAIL %s_latency: got %0d cycles expected <= 3", tag, lat);
      end
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_en"}, 64'(en), 64'(en_m));
    chk({tag, "_m"}, m, m_m);
  endtask

  initial begin
    logic [3:0]  op, ch;
    logic [31:0] p;
    logic [47:0] rx, etx;
    int          nrx, ntx, bp;
    logic [1:0]  sv;

    tbl[0]  = '{rx: b6(8'h11, 8'h78, 8'h56, 8'h34, 8'h12), nrx: 5, tx: b6(8'h41), ntx: 1,
                setv: 2'b00, en: 2'b00, m: 64'h12345678_00000000, bp: 0};
    tbl[1]  = '{rx: b6(8'h40), nrx: 1, tx: b6(8'h41), ntx: 1,
                setv: 2'b01, en: 2'b00, m: 64'h12345678_00000000, bp: 0};
    tbl[2]  = '{rx: b6(8'h21), nrx: 1, tx: b6(8'h41), ntx: 1,
                setv: 2'b00, en: 2'b10, m: 64'h12345678_00000000, bp: 0};
    tbl[3]  = '{rx: b6(8'h13), nrx: 1, tx: b6(8'h4E), ntx: 1,
                setv: 2'b00, en: 2'b10, m: 64'h12345678_00000000, bp: 0};
    tbl[4]  = '{rx: b6(8'hF0), nrx: 1, tx: b6(8'h4E), ntx: 1,
                setv: 2'b00, en: 2'b10, m: 64'h12345678_00000000, bp: 0};
    tbl[5]  = '{rx: b6(8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE), nrx: 5, tx: b6(8'h41), ntx: 1,
                setv: 2'b00, en: 2'b10, m: 64'h12345678_DEADBEEF, bp: 0};
    tbl[6]  = '{rx: b6(8'h50), nrx: 1, tx: b6(8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h41), ntx: 5,
                setv: 2'b00, en: 2'b10, m: 64'h12345678_DEADBEEF, bp: 5};
    tbl[7]  = '{rx: b6(8'h6F), nrx: 1, tx: b6(8'h41), ntx: 1,
                setv: 2'b11, en: 2'b10, m: 64'h12345678_DEADBEEF, bp: 0};
    tbl[8]  = '{rx: b6(8'h31, 8'h20), nrx: 2, tx: b6(8'h41), ntx: 1,
                setv: 2'b00, en: 2'b00, m: 64'h12345678_DEADBEEF, bp: 0};
    tbl[9]  = '{rx: b6(8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55), nrx: 6, tx: b6(8'h41), ntx: 1,
                setv: 2'b00, en: 2'b00, m: 64'h04030201_DEADBEEF, bp: 0};
    tbl[10] = '{rx: b6(8'h51), nrx: 1, tx: b6(8'h01, 8'h02, 8'h03, 8'h04, 8'h41), ntx: 5,
                setv: 2'b00, en: 2'b00, m: 64'h04030201_DEADBEEF, bp: 2};
    tbl[11] = '{rx: b6(8'h70), nrx: 1, tx: b6(8'h4E), ntx: 1,
                setv: 2'b00, en: 2'b00, m: 64'h04030201_DEADBEEF, bp: 0};
    tbl[12] = '{rx: b6(8'h22), nrx: 1, tx: b6(8'h4E), ntx: 1,
                setv: 2'b00, en: 2'b00, m: 64'h04030201_DEADBEEF, bp: 0};
    tbl[13] = '{rx: b6(8'h30), nrx: 1, tx: b6(8'h41), ntx: 1,
                setv: 2'b00, en: 2'b00, m: 64'h04030201_DEADBEEF, bp: 0};

    repeat (3) @(negedge clk);
    chk("rst_en", 64'(en), 64'h0);
    chk("rst_m", m, 64'h0);
    chk("rst_set", 64'(set), 64'h0);
    chk("rst_transmit", 64'(transmit), 64'h0);
    chk("rst_tx_byte", 64'(tx_byte), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start_frame(tbl[i].bp);
      for (int j = 0; j < tbl[i].nrx; j++) send_byte(tbl[i].rx[j*8 +: 8]);
      finish_frame(tbl[i].tx, tbl[i].ntx, tbl[i].setv, 1'b1, $sformatf("v%0d", i));
      chk($sformatf("v%0d_en", i), 64'(en), 64'(tbl[i].en));
      chk($sformatf("v%0d_m", i), m, tbl[i].m);
    end
    en_m = 2'b00;
    m_m  = 64'h04030201_DEADBEEF;

    // Payload stalls for the full timeout window: frame dropped with NAK
    start_frame(0);
    send_byte(8'h10);
    send_byte(8'hAA);
    finish_frame(b6(8'h4E), 1, 2'b00, 1'b0, "tmo");
    chk_state("tmo");
    start_frame(0);
    send_byte(8'h20);
    en_m = 2'b01;
    finish_frame(b6(8'h41), 1, 2'b00, 1'b1, "tmo_en");
    chk_state("tmo_en");

    // A byte landing exactly in the expiry cycle is still accepted
    start_frame(0);
    send_byte(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TIMEOUT - 1) @(negedge clk);
    send_byte(8'h33);
    send_byte(8'h44);
    m_m[63:32] = 32'h44332211;
    finish_frame(b6(8'h41), 1, 2'b00, 1'b1, "tmo_edge");
    chk_state("tmo_edge");

    // Reset in the middle of a LOAD, then a command on the first cycle after release
    start_frame(0);
    send_byte(8'h10);
    send_byte(8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 64'(en), 64'h0);
    chk("mid_rst_m", m, 64'h0);
    chk("mid_rst_set", 64'(set), 64'h0);
    chk("mid_rst_transmit", 64'(transmit), 64'h0);
    chk("mid_rst_tx_byte", 64'(tx_byte), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h30);
    en_m = 2'b00;
    m_m  = 64'h0;
    finish_frame(b6(8'h41), 1, 2'b00, 1'b1, "post_rst");
    chk_state("post_rst");

    // Randomized frames against the channel-level model
    for (int i = 0; i < 60; i++) begin
      op  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
      ch  = 4'($urandom_range(0, 3));
      p   = $urandom;
      bp  = int'($urandom_range(0, 5));
      rx  = {40'h0, op, ch};
      nrx = 1;
      etx = {40'h0, 8'h41};
      ntx = 1;
      sv  = 2'b00;
      if (op == 4'h6) begin
        sv = 2'b11;
      end else if (op >= 4'h1 && op <= 4'h5 && ch < 4'd2) begin
        case (op)
          4'h1: begin
            rx  = {8'h00, p, op, ch};
            nrx = 5;
            if (ch[0]) m_m[63:32] = p;
            else       m_m[31:0]  = p;
          end
          4'h2: en_m[ch[0]] = 1'b1;
          4'h3: en_m[ch[0]] = 1'b0;
          4'h4: sv = ch[0] ? 2'b10 : 2'b01;
          default: begin
            etx = {8'h00, 8'h41, (ch[0] ? m_m[63:32] : m_m[31:0])};
            ntx = 5;
          end
        endcase
      end else begin
        etx = {40'h0, 8'h4E};
      end
      start_frame(bp);
      for (int j = 0; j < nrx; j++) send_byte(rx[j*8 +: 8]);
      finish_frame(etx, ntx, sv, 1'b1, $sformatf("r%0d", i));
      chk_state($sformatf("r%0d", i));
    end

    chk("busy_violations", 64'(busy_viol), 64'h0);
    chk("tx_byte_stability", 64'(stable_viol), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
